// File: rtl/wb_copy_master_if.sv
// Wishbone classic bus bundle between the copy master and its slave.
//
// Signals (the master drives the *_o signals, the slave drives the *_i signals):
//   cyc_o, stb_o, we_o  cycle, strobe and write-enable
//   sel_o[3:0]          byte selects
//   adr_o[31:0]         byte address
//   dat_o[31:0]         write data
//   dat_i[31:0]         read data
//   ack_i               slave acknowledge
interface wb_copy_master_if;
    logic        cyc_o;
    logic        stb_o;
    logic        we_o;
    logic [3:0]  sel_o;
    logic [31:0] adr_o;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic        ack_i;

    modport master (
        output cyc_o, stb_o, we_o, sel_o, adr_o, dat_o,
        input  dat_i, ack_i
    );

    modport slave (
        input  cyc_o, stb_o, we_o, sel_o, adr_o, dat_o,
        output dat_i, ack_i
    );
endinterface

// File: rtl/wb_copy_master.sv
// wb_copy_master: word-by-word memory copy engine on a Wishbone classic bus.
// Each word is read from src and then written to dst; addresses are word
// aligned on acceptance and advance by 4 with 32-bit wrap.
//
// Ports:
//   wb_clk_i, wb_rst_n_i        clock, asynchronous active-low reset
//   cmd_valid_i / cmd_ready_o   command handshake
//   cmd_src_i, cmd_dst_i        source / destination byte addresses
//   cmd_len_i                   number of 32-bit words to copy
//   busy_o                      high while reading or writing
//   done_o                      one-cycle pulse on successful completion
//   err_o                       one-cycle pulse on timeout abort
//   wbm                         Wishbone master port (wb_copy_master_if.master)
//
// Parameter TIMEOUT_CYCLES (1..255): longest wait for ack in one bus phase.
// Optional feature macro: WB_COPY_MASTER_TIMEOUT_EN. When defined, a phase
// that sees no ack for TIMEOUT_CYCLES cycles aborts through ERR. When
// undefined, the block waits for ack indefinitely and err_o is tied low.
module wb_copy_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_n_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [31:0]        cmd_src_i,
    input  logic [31:0]        cmd_dst_i,
    input  logic [15:0]        cmd_len_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    wb_copy_master_if.master   wbm
);

`ifdef WB_COPY_MASTER_TIMEOUT_EN
    typedef enum logic [2:0] {IDLE, RD, WR, DONE, ERR} state_t;
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_q, wait_d;
    logic       err_q, err_d;
`else
    typedef enum logic [2:0] {IDLE, RD, WR, DONE} state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] src_q, src_d;
    logic [31:0] dst_q, dst_d;
    logic [15:0] len_q, len_d;
    logic [31:0] data_q, data_d;

    // Registered copies of every output, decoded from the next state.
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;

    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        data_d  = data_q;
`ifdef WB_COPY_MASTER_TIMEOUT_EN
        // Any phase change or ack restarts the wait count from zero.
        wait_d  = 8'd0;
`endif
        unique case (state_q)
            IDLE: begin
                if (cmd_valid_i && ready_q) begin
                    src_d   = cmd_src_i & 32'hFFFF_FFFC;
                    dst_d   = cmd_dst_i & 32'hFFFF_FFFC;
                    len_d   = cmd_len_i;
                    state_d = (cmd_len_i == 16'd0) ? DONE : RD;
                end
            end
            RD: begin
                if (wbm.ack_i) begin
                    data_d  = wbm.dat_i;
                    state_d = WR;
                end
`ifdef WB_COPY_MASTER_TIMEOUT_EN
                else if (wait_q == TIMEOUT_LAST) state_d = ERR;
                else wait_d = wait_q + 8'd1;
`endif
            end
            WR: begin
                if (wbm.ack_i) begin
                    src_d   = src_q + 32'd4;
                    dst_d   = dst_q + 32'd4;
                    len_d   = len_q - 16'd1;
                    state_d = (len_q == 16'd1) ? DONE : RD;
                end
`ifdef WB_COPY_MASTER_TIMEOUT_EN
                else if (wait_q == TIMEOUT_LAST) state_d = ERR;
                else wait_d = wait_q + 8'd1;
`endif
            end
            DONE:    state_d = IDLE;
`ifdef WB_COPY_MASTER_TIMEOUT_EN
            ERR:     state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase

        // Outputs follow the state being entered so they are valid the same
        // cycle the state register updates.
        ready_d = (state_d == IDLE);
        busy_d  = (state_d == RD) || (state_d == WR);
        done_d  = (state_d == DONE);
        cyc_d   = busy_d;
        we_d    = (state_d == WR);
        sel_d   = busy_d ? 4'hF : 4'h0;
        adr_d   = (state_d == RD) ? src_d : ((state_d == WR) ? dst_d : 32'd0);
        dat_d   = (state_d == WR) ? data_d : 32'd0;
`ifdef WB_COPY_MASTER_TIMEOUT_EN
        err_d   = (state_d == ERR);
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before the edge, independent of statement order.
    // NOTE: the data and address registers are reset too, because outputs
    // must read zero the moment reset asserts, not after the next command.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
`ifdef WB_COPY_MASTER_TIMEOUT_EN
            wait_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
`ifdef WB_COPY_MASTER_TIMEOUT_EN
            wait_q  <= wait_d;
            err_q   <= err_d;
`endif
        end
    end

    assign cmd_ready_o = ready_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign wbm.cyc_o   = cyc_q;
    assign wbm.stb_o   = cyc_q;  // classic single-beat: strobe tracks cycle
    assign wbm.we_o    = we_q;
    assign wbm.sel_o   = sel_q;
    assign wbm.adr_o   = adr_q;
    assign wbm.dat_o   = dat_q;
`ifdef WB_COPY_MASTER_TIMEOUT_EN
    assign err_o       = err_q;
`else
    assign err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_wb_copy_master.sv
// Testbench for wb_copy_master: table of directed copy commands against a
// Wishbone slave model with programmable wait states, plus hand-written
// sequences for reset, ignored commands/acks and the no-ack case.
module tb_wb_copy_master;
    localparam int unsigned TIMEOUT = 4;

    typedef struct {
        string       name;
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] len;
        logic [7:0]  waits;
        bit          noise;        // offer a second command while busy
        int          done_cyc;     // sample index (1 = first cycle after accept) of done_o
        int          cyc_cyc;      // number of cycles cyc_o is high
        logic [31:0] first_wdata;  // data of the first write
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_src = '0;
    logic [31:0] cmd_dst = '0;
    logic [15:0] cmd_len = '0;
    logic        busy, done, err;

    wb_copy_master_if wbm();

    wb_copy_master #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .wb_clk_i    (clk),
        .wb_rst_n_i  (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_src_i   (cmd_src),
        .cmd_dst_i   (cmd_dst),
        .cmd_len_i   (cmd_len),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .wbm         (wbm)
    );

    always #5 clk = ~clk;

    // ---------------- slave model ----------------
    logic [7:0]  wait_states = 8'd0;
    logic        ack_en = 1'b1;
    logic        stray_ack = 1'b0;
    logic [7:0]  wcnt = 8'd0;
    logic        in_wait = 1'b0;
    logic [31:0] wait_adr = '0;
    logic        wait_we = 1'b0;
    int          unstable = 0;
    logic [31:0] rd_adr_q[$];
    logic [31:0] wr_adr_q[$];
    logic [31:0] wr_dat_q[$];

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a == 32'h2000_0100) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_5A5A);
    endfunction

    assign wbm.ack_i = (ack_en && wbm.cyc_o && wbm.stb_o && (wcnt >= wait_states)) || stray_ack;
    assign wbm.dat_i = mem_val(wbm.adr_o);

    always @(posedge clk) begin
        if (wbm.cyc_o && wbm.stb_o && wbm.ack_i) begin
            wcnt    <= 8'd0;
            in_wait <= 1'b0;
            if (wbm.we_o) begin
                wr_adr_q.push_back(wbm.adr_o);
                wr_dat_q.push_back(wbm.dat_o);
            end else begin
                rd_adr_q.push_back(wbm.adr_o);
            end
        end else if (wbm.cyc_o && wbm.stb_o) begin
            wcnt <= wcnt + 8'd1;
            if (in_wait && ((wbm.adr_o != wait_adr) || (wbm.we_o != wait_we)))
                unstable <= unstable + 1;
            in_wait  <= 1'b1;
            wait_adr <= wbm.adr_o;
            wait_we  <= wbm.we_o;
        end else begin
            wcnt    <= 8'd0;
            in_wait <= 1'b0;
        end
    end

    // ---------------- checking ----------------
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [31:0] src, input logic [31:0] dst,
                                input logic [15:0] len, input logic [7:0] waits, input bit noise,
                                input int done_cyc, input int cyc_cyc, input logic [31:0] first_wdata);
        vec_t v;
        v.name = name; v.src = src; v.dst = dst; v.len = len; v.waits = waits;
        v.noise = noise; v.done_cyc = done_cyc; v.cyc_cyc = cyc_cyc; v.first_wdata = first_wdata;
        return v;
    endfunction

    task automatic run_cmd(input vec_t v);
        int          cnt, cyc_cnt, err_cnt, ready_wait;
        bit          seen_done;
        logic        busy_first, ready_first;
        logic [31:0] exp_src, exp_dst, exp_dat;
        rd_adr_q.delete();
        wr_adr_q.delete();
        wr_dat_q.delete();
        wait_states = v.waits;
        ready_wait = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && ready_wait < 20) begin
            @(negedge clk);
            ready_wait++;
        end
        check({v.name, " ready_before"}, {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_src = v.src; cmd_dst = v.dst; cmd_len = v.len;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cnt = 1; cyc_cnt = 0; err_cnt = 0; seen_done = 1'b0;
        busy_first = busy; ready_first = cmd_ready;
        while (!seen_done && cnt <= 2000) begin
            if (wbm.cyc_o === 1'b1) cyc_cnt++;
            if (err === 1'b1) err_cnt++;
            if (done === 1'b1) seen_done = 1'b1;
            else begin
                if (v.noise && cnt == 2) begin
                    cmd_valid = 1'b1; cmd_src = 32'h7777_0000; cmd_dst = 32'h7777_1000; cmd_len = 16'd9;
                end else if (v.noise && cnt == 5) begin
                    cmd_valid = 1'b0;
                end
                @(posedge clk); #1;
                cnt++;
            end
        end
        check({v.name, " done_cycle"}, 32'(cnt), 32'(v.done_cyc));
        check({v.name, " cyc_cycles"}, 32'(cyc_cnt), 32'(v.cyc_cyc));
        check({v.name, " err_pulses"}, 32'(err_cnt), 32'd0);
        check({v.name, " busy_first"}, {31'd0, busy_first}, {31'd0, v.len != 16'd0});
        check({v.name, " ready_first"}, {31'd0, ready_first}, 32'd0);
        @(posedge clk); #1;
        check({v.name, " done_once"}, {31'd0, done}, 32'd0);
        check({v.name, " ready_after"}, {31'd0, cmd_ready}, 32'd1);
        check({v.name, " reads"}, 32'(rd_adr_q.size()), 32'(v.len));
        check({v.name, " writes"}, 32'(wr_adr_q.size()), 32'(v.len));
        for (int i = 0; i < int'(v.len); i++) begin
            exp_src = (v.src & 32'hFFFF_FFFC) + 32'(4 * i);
            exp_dst = (v.dst & 32'hFFFF_FFFC) + 32'(4 * i);
            exp_dat = (i == 0) ? v.first_wdata : mem_val(exp_src);
            if (i < rd_adr_q.size()) check($sformatf("%s rd_adr[%0d]", v.name, i), rd_adr_q[i], exp_src);
            if (i < wr_adr_q.size()) check($sformatf("%s wr_adr[%0d]", v.name, i), wr_adr_q[i], exp_dst);
            if (i < wr_dat_q.size()) check($sformatf("%s wr_dat[%0d]", v.name, i), wr_dat_q[i], exp_dat);
        end
    endtask

    vec_t vecs[6];

    initial begin
        int  cnt, cyc_cnt, done_cnt, err_cnt, low_cnt;
        bit  seen;

        vecs[0] = mk("zero_wait_len3", 32'h3800_0000, 32'h3000_0010, 16'd3, 8'd0, 1'b0, 7, 6, 32'h625A_5A5A);
        vecs[1] = mk("wait2_len1",     32'h2000_0100, 32'h4000_0000, 16'd1, 8'd2, 1'b0, 7, 6, 32'hDEAD_BEEF);
        vecs[2] = mk("src_wrap",       32'hFFFF_FFFC, 32'h1000_0000, 16'd2, 8'd0, 1'b0, 5, 4, 32'hA5A5_A5A6);
        vecs[3] = mk("unaligned",      32'h0000_1003, 32'h0000_2002, 16'd2, 8'd1, 1'b0, 9, 8, 32'h5A5A_4A5A);
        vecs[4] = mk("len0",           32'h1234_5678, 32'h8765_4320, 16'd0, 8'd0, 1'b0, 1, 0, 32'h0);
        vecs[5] = mk("busy_cmd_ignored", 32'h5000_0000, 32'h6000_0000, 16'd2, 8'd2, 1'b1, 13, 12, 32'h0A5A_5A5A);

        // Reset state: everything low, including cmd_ready.
        #3;
        check("rst cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst busy_done_err", {29'd0, busy, done, err}, 32'd0);
        check("rst bus_ctrl", {29'd0, wbm.cyc_o, wbm.stb_o, wbm.we_o}, 32'd0);
        check("rst adr", wbm.adr_o, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #2;
        check("ready_before_first_edge", {31'd0, cmd_ready}, 32'd0);
        @(posedge clk); #1;
        check("ready_after_first_edge", {31'd0, cmd_ready}, 32'd1);

        for (int i = 0; i < 6; i++) run_cmd(vecs[i]);
        check("adr_we_stable_in_waits", 32'(unstable), 32'd0);

        // Ack with no strobe in IDLE is ignored.
        rd_adr_q.delete();
        @(negedge clk); stray_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("stray_ack state", {28'd0, busy, done, wbm.cyc_o, cmd_ready}, 32'd1);
        @(negedge clk); stray_ack = 1'b0;

        // Slave that never acknowledges.
        ack_en = 1'b0; wait_states = 8'd0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_src = 32'h0000_0100; cmd_dst = 32'h0000_0200; cmd_len = 16'd2;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
`ifdef WB_COPY_MASTER_TIMEOUT_EN
        cnt = 1; cyc_cnt = 0; done_cnt = 0; seen = 1'b0;
        while (!seen && cnt <= 50) begin
            if (wbm.cyc_o === 1'b1) cyc_cnt++;
            if (done === 1'b1) done_cnt++;
            if (err === 1'b1) seen = 1'b1;
            else begin
                @(posedge clk); #1;
                cnt++;
            end
        end
        check("timeout err_cycle", 32'(cnt), 32'd5);
        check("timeout cyc_cycles", 32'(cyc_cnt), 32'(TIMEOUT));
        check("timeout cyc_dropped", {31'd0, wbm.cyc_o}, 32'd0);
        check("timeout no_done", 32'(done_cnt), 32'd0);
        @(posedge clk); #1;
        check("timeout err_once", {31'd0, err}, 32'd0);
        check("timeout ready_after", {31'd0, cmd_ready}, 32'd1);
`else
        low_cnt = 0; err_cnt = 0; done_cnt = 0;
        repeat (300) begin
            if (wbm.cyc_o !== 1'b1) low_cnt++;
            if (err === 1'b1) err_cnt++;
            if (done === 1'b1) done_cnt++;
            @(posedge clk); #1;
        end
        check("noack cyc_held", 32'(low_cnt), 32'd0);
        check("noack no_err_done", 32'(err_cnt + done_cnt), 32'd0);
        @(negedge clk); rst_n = 1'b0;
        #1;
        check("noack reset_cyc", {31'd0, wbm.cyc_o}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
`endif
        ack_en = 1'b1;

        // Reset during the write of word 2 of 4.
        rd_adr_q.delete(); wr_adr_q.delete(); wr_dat_q.delete();
        wait_states = 8'd1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_src = 32'h0000_8000; cmd_dst = 32'h0000_9000; cmd_len = 16'd4;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cnt = 0;
        while (!(wbm.cyc_o === 1'b1 && wbm.we_o === 1'b1 && wr_adr_q.size() == 1) && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("midwr reached_word2_write", wbm.adr_o, 32'h0000_9004);
        #2;
        rst_n = 1'b0;
        #1;
        check("midwr async bus_ctrl", {29'd0, wbm.cyc_o, wbm.stb_o, wbm.we_o}, 32'd0);
        check("midwr async adr_dat", wbm.adr_o | wbm.dat_o | {28'd0, wbm.sel_o}, 32'd0);
        check("midwr async status", {28'd0, cmd_ready, busy, done, err}, 32'd0);
        @(posedge clk); #1;
        check("midwr held no_done_err", {30'd0, done, err}, 32'd0);
        check("midwr writes_logged", 32'(wr_adr_q.size()), 32'd1);
        @(negedge clk); rst_n = 1'b1;
        #2;
        check("midwr ready_low_after_release", {31'd0, cmd_ready}, 32'd0);
        run_cmd(mk("after_reset", 32'h0000_A000, 32'h0000_B000, 16'd2, 8'd0, 1'b0, 5, 4, 32'h5A5A_FA5A));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
